// File: rtl/int_mult_seq.sv
// int_mult_seq: iterative shift-add multiplier, signed/unsigned, full double-width product.
// One operation in flight; valid/ready handshakes on input and output.
module int_mult_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   m_cand,
    input  logic [DATA_WIDTH-1:0]   m_plier,
    input  logic                    is_signed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] result
);
    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [PW-1:0]         acc_q, acc_d, result_q, result_d, pp;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  last;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign last      = cnt_q == CW'(N - 1);
    // Partial product of the magnitude with the low multiplier digit, placed at its digit weight
    assign pp = ({{DATA_WIDTH{1'b0}}, op_a_q} * {{(PW-BITS_PER_CYCLE){1'b0}}, op_b_q[BITS_PER_CYCLE-1:0]})
                << (int'(cnt_q) * BITS_PER_CYCLE);
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_a_d  = (is_signed && m_cand[DATA_WIDTH-1]) ? -m_cand : m_cand;
                op_b_d  = (is_signed && m_plier[DATA_WIDTH-1]) ? -m_plier : m_plier;
                neg_d   = is_signed & (m_cand[DATA_WIDTH-1] ^ m_plier[DATA_WIDTH-1]);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                acc_d   = acc_q + pp;
                op_b_d  = op_b_q >> BITS_PER_CYCLE;
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? FIX : BUSY;
            end
            FIX: begin
                result_d = neg_q ? -acc_q : acc_q;
                state_d  = DONE;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end
endmodule
